// File: rtl/mii_tx_framer_if.sv
// Byte-lane packet stream into the MII transmit framer.
// The master is the MAC frame source and the slave is the framer.
interface mii_tx_framer_if #(
  parameter int LANES = 8
) ();
  logic [8*LANES-1:0] i_tdata;
  logic [LANES-1:0]   i_tkeep;
  logic               i_tvalid;
  logic               i_tlast;
  logic               i_terr;
  logic               o_tready;

  modport master (
    output i_tdata, i_tkeep, i_tvalid, i_tlast, i_terr,
    input  o_tready
  );

  modport slave (
    input  i_tdata, i_tkeep, i_tvalid, i_tlast, i_terr,
    output o_tready
  );
endinterface

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: turns a byte-lane packet stream into a continuous wide MII
// data/control word stream. It inserts /S/ + preamble + SFD, zero-pads short
// frames, places /T/, enforces an inter-frame gap and marks corrupted beats.
module mii_tx_framer #(
  parameter int LANES     = 8,
  parameter int MIN_FRAME = 60,
  parameter int IFG_WORDS = 1
) (
  input  logic               clk,
  input  logic               i_rst_n,
  mii_tx_framer_if.slave     s_in,
  output logic [8*LANES-1:0] o_mii_data,
  output logic [LANES-1:0]   o_mii_ctrl,
  output logic               o_tx_active,
  output logic               o_frame_done
);
  localparam int DW        = 8 * LANES;
  localparam int PRE_WORDS = 8 / LANES;

  localparam logic [7:0]       CH_IDLE    = 8'h07;
  localparam logic [7:0]       CH_TERM    = 8'hFD;
  localparam logic [7:0]       CH_ERR     = 8'hFE;
  localparam logic [63:0]      PRE_SEQ    = 64'hD5555555555555FB;
  localparam logic [DW-1:0]    IDLE_WORD  = {LANES{CH_IDLE}};
  localparam logic [DW-1:0]    ERR_WORD   = {LANES{CH_ERR}};
  localparam logic [LANES-1:0] CTRL_START = {{(LANES-1){1'b0}}, 1'b1};
  localparam logic [1:0]       PRE_LAST   = 2'(PRE_WORDS - 1);
  localparam logic [3:0]       IFG_LAST   = 4'(IFG_WORDS - 1);
  localparam logic [4:0]       LANES5     = 5'(LANES);
  localparam logic [15:0]      LANES16    = 16'(LANES);
  localparam logic [15:0]      MIN16      = 16'(MIN_FRAME);

  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_PAD, ST_IFG} state_t;

  // With no gap configured the word after /T/ comes straight from IDLE.
  localparam state_t AFTER_TERM = (IFG_WORDS == 0) ? ST_IDLE : ST_IFG;

  state_t             state_q, state_d;
  logic [1:0]         pre_cnt_q, pre_cnt_d;
  logic [3:0]         ifg_cnt_q, ifg_cnt_d;
  logic [15:0]        byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]      mii_data_q, mii_data_d;
  logic [LANES-1:0]   mii_ctrl_q, mii_ctrl_d;
  logic               tx_active_q, tx_active_d;
  logic               frame_done_q, frame_done_d;

  logic               tready;
  logic [4:0]         keep_cnt;
  logic [DW-1:0]      lane_src;
  logic [4:0]         live_lanes;
  logic [4:0]         term_pos;
  logic               build;
  logic               corrupt;
  logic [16:0]        total;
  logic [15:0]        rem;

  function automatic logic [4:0] popcount(input logic [LANES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < LANES; k++) c = c + {4'd0, v[k]};
    return c;
  endfunction

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  assign keep_cnt      = popcount(s_in.i_tkeep);
  assign s_in.o_tready = tready;
  assign o_mii_data    = mii_data_q;
  assign o_mii_ctrl    = mii_ctrl_q;
  assign o_tx_active   = tx_active_q;
  assign o_frame_done  = frame_done_q;

  // Next-state logic and the next registered MII word; data, pad and /T/
  // words share one lane builder driven by term_pos and live_lanes.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    mii_data_d   = IDLE_WORD;
    mii_ctrl_d   = '1;
    tx_active_d  = 1'b0;
    frame_done_d = 1'b0;
    tready       = 1'b0;
    lane_src     = '0;
    live_lanes   = '0;
    term_pos     = LANES5;
    build        = 1'b0;
    corrupt      = 1'b0;
    total        = {1'b0, byte_cnt_q} + {12'd0, keep_cnt};
    rem          = (byte_cnt_q >= MIN16) ? 16'd0 : (MIN16 - byte_cnt_q);

    case (state_q)
      ST_IDLE: begin
        if (s_in.i_tvalid) begin
          state_d   = ST_PRE;
          pre_cnt_d = '0;
        end
      end
      ST_PRE: begin
        mii_data_d  = PRE_SEQ[DW*int'(pre_cnt_q) +: DW];
        mii_ctrl_d  = (pre_cnt_q == 2'd0) ? CTRL_START : '0;
        tx_active_d = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          state_d    = ST_DATA;
          pre_cnt_d  = '0;
          byte_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + 2'd1;
        end
      end
      ST_DATA: begin
        tready      = 1'b1;
        tx_active_d = 1'b1;
        if (s_in.i_tvalid) begin
          build      = 1'b1;
          lane_src   = s_in.i_tdata;
          live_lanes = keep_cnt;
          corrupt    = s_in.i_terr;
          if (!s_in.i_tlast) begin
            byte_cnt_d = sat16(total);
          end else if (total >= {1'b0, MIN16}) begin
            byte_cnt_d = sat16(total);
            if (keep_cnt < LANES5) begin
              term_pos     = keep_cnt;
              frame_done_d = 1'b1;
              ifg_cnt_d    = '0;
              state_d      = AFTER_TERM;
            end else begin
              state_d = ST_PAD;
            end
          end else begin
            byte_cnt_d = sat16({1'b0, byte_cnt_q} + {1'b0, LANES16});
            state_d    = ST_PAD;
          end
        end else begin
          // A source underrun mid-frame cannot be hidden, so it is marked /E/.
          mii_data_d = ERR_WORD;
        end
      end
      ST_PAD: begin
        tx_active_d = 1'b1;
        build       = 1'b1;
        if (rem < LANES16) begin
          term_pos     = rem[4:0];
          frame_done_d = 1'b1;
          ifg_cnt_d    = '0;
          state_d      = AFTER_TERM;
        end else begin
          byte_cnt_d = sat16({1'b0, byte_cnt_q} + {1'b0, LANES16});
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == IFG_LAST) begin
          ifg_cnt_d = '0;
          pre_cnt_d = '0;
          state_d   = s_in.i_tvalid ? ST_PRE : ST_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (build) begin
      for (int k = 0; k < LANES; k++) begin
        if (5'(k) < term_pos) begin
          mii_data_d[8*k +: 8] = (5'(k) < live_lanes) ? lane_src[8*k +: 8] : 8'h00;
          mii_ctrl_d[k]        = 1'b0;
        end else if (5'(k) == term_pos) begin
          mii_data_d[8*k +: 8] = CH_TERM;
          mii_ctrl_d[k]        = 1'b1;
        end else begin
          mii_data_d[8*k +: 8] = CH_IDLE;
          mii_ctrl_d[k]        = 1'b1;
        end
      end
      if (corrupt) begin
        for (int k = 0; k < LANES; k++) begin
          if (!mii_ctrl_d[k]) begin
            mii_data_d[8*k +: 8] = CH_ERR;
            mii_ctrl_d[k]        = 1'b1;
          end
        end
      end
    end
  end

  // State, counters and the registered MII outputs; reset forces idle at once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= '0;
      ifg_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      mii_data_q   <= IDLE_WORD;
      mii_ctrl_q   <= '1;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      mii_data_q   <= mii_data_d;
      mii_ctrl_q   <= mii_ctrl_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_mii_tx_framer.sv
// Testbench for mii_tx_framer: an 8-lane instance (IFG 1) and a 4-lane
// instance (IFG 3). Expected words are queued before stimulus; per-DUT
// monitors pop and compare each word of a frame on the falling edge.
module tb_mii_tx_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  mii_tx_framer_if #(.LANES(8)) a_if ();
  mii_tx_framer_if #(.LANES(4)) b_if ();

  logic [63:0] a_data;
  logic [7:0]  a_ctrl;
  logic        a_act, a_done;
  logic [31:0] b_data;
  logic [3:0]  b_ctrl;
  logic        b_act, b_done;

  mii_tx_framer #(.LANES(8), .MIN_FRAME(60), .IFG_WORDS(1)) dut_a (
    .clk(clk), .i_rst_n(rst_a_n), .s_in(a_if),
    .o_mii_data(a_data), .o_mii_ctrl(a_ctrl),
    .o_tx_active(a_act), .o_frame_done(a_done)
  );

  mii_tx_framer #(.LANES(4), .MIN_FRAME(60), .IFG_WORDS(3)) dut_b (
    .clk(clk), .i_rst_n(rst_b_n), .s_in(b_if),
    .o_mii_data(b_data), .o_mii_ctrl(b_ctrl),
    .o_tx_active(b_act), .o_frame_done(b_done)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        act;
    logic        done;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  bit   win_a = 1'b0;
  bit   win_b = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [63:0] IDLE8 = 64'h0707070707070707;
  localparam logic [63:0] IDLE4 = 64'h0000000007070707;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: bound expired before completion", name);
  endtask

  function automatic logic [63:0] beat_word(input int lanes, input int seed, input int len, input int b);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < lanes; k++)
      if (b*lanes + k < len) w[8*k +: 8] = 8'((seed*29 + (b*lanes + k)*13 + 5) & 255);
    return w;
  endfunction

  function automatic logic [7:0] keep_of(input int lanes, input int len, input int b);
    logic [7:0] kp;
    kp = '0;
    for (int k = 0; k < lanes; k++)
      if (b*lanes + k < len) kp[k] = 1'b1;
    return kp;
  endfunction

  task automatic push_exp(input bit sel_b, input logic [63:0] d, input logic [7:0] c, input logic act, input logic done);
    exp_t e;
    e.data = d;
    e.ctrl = c;
    e.act  = act;
    e.done = done;
    if (sel_b) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic exp_pre(input bit sel_b);
    if (sel_b) begin
      push_exp(1'b1, 64'h00000000555555FB, 8'h01, 1'b1, 1'b0);
      push_exp(1'b1, 64'h00000000D5555555, 8'h00, 1'b1, 1'b0);
    end else begin
      push_exp(1'b0, 64'hD5555555555555FB, 8'h01, 1'b1, 1'b0);
    end
  endtask

  task automatic exp_data(input bit sel_b, input int seed, input int len, input int from_b, input int to_b);
    for (int b = from_b; b < to_b; b++)
      push_exp(sel_b, beat_word(sel_b ? 4 : 8, seed, len, b), 8'h00, 1'b1, 1'b0);
  endtask

  task automatic exp_idle(input bit sel_b, input int n);
    for (int i = 0; i < n; i++)
      push_exp(sel_b, sel_b ? IDLE4 : IDLE8, sel_b ? 8'h0F : 8'hFF, 1'b0, 1'b0);
  endtask

  // Drives one frame beat by beat, advancing on each accepted handshake.
  // With hold set, i_tvalid stays high so the next frame follows directly.
  task automatic applyStimulus(input bit sel_b, input int len, input int seed, input int err_beat,
                               input int max_beats, input bit hold);
    int lanes, nb, last_b, b, guard;
    logic [63:0] w;
    logic [7:0]  kp;
    logic        rdy;
    lanes  = sel_b ? 4 : 8;
    last_b = (len + lanes - 1) / lanes - 1;
    nb     = (max_beats < last_b + 1) ? max_beats : last_b + 1;
    b      = 0;
    guard  = 0;
    while (b < nb) begin
      @(negedge clk);
      w  = beat_word(lanes, seed, len, b);
      kp = keep_of(lanes, len, b);
      if (sel_b) begin
        b_if.i_tdata  = w[31:0];
        b_if.i_tkeep  = kp[3:0];
        b_if.i_tvalid = 1'b1;
        b_if.i_tlast  = (b == last_b);
        b_if.i_terr   = (b == err_beat);
        rdy = b_if.o_tready;
      end else begin
        a_if.i_tdata  = w;
        a_if.i_tkeep  = kp;
        a_if.i_tvalid = 1'b1;
        a_if.i_tlast  = (b == last_b);
        a_if.i_terr   = (b == err_beat);
        rdy = a_if.o_tready;
      end
      if (rdy) b++;
      guard++;
      if (guard > 500) begin
        report_timeout("handshake");
        break;
      end
    end
    if (!hold) begin
      @(negedge clk);
      if (sel_b) begin
        b_if.i_tvalid = 1'b0; b_if.i_tlast = 1'b0; b_if.i_terr = 1'b0;
      end else begin
        a_if.i_tvalid = 1'b0; a_if.i_tlast = 1'b0; a_if.i_terr = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input bit sel_b);
    int g;
    g = 0;
    while ((sel_b ? qb.size() : qa.size()) != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if ((sel_b ? qb.size() : qa.size()) != 0) report_timeout(sel_b ? "B_drain" : "A_drain");
    repeat (3) @(negedge clk);
  endtask

  // Monitor for the 8-lane DUT: a frame window opens on the first active
  // word and stays open while expected words remain.
  always @(negedge clk) begin
    if (!rst_a_n) begin
      win_a = 1'b0;
    end else begin
      if (!win_a && (a_act || a_done)) begin
        if (qa.size() != 0) win_a = 1'b1;
        else checkOutput("A_unexpected_activity", {62'd0, a_act, a_done}, 64'd0);
      end
      if (win_a) begin
        ea = qa.pop_front();
        checkOutput("A_data", a_data, ea.data);
        checkOutput("A_ctrl", {56'd0, a_ctrl}, {56'd0, ea.ctrl});
        checkOutput("A_tx_active", {63'd0, a_act}, {63'd0, ea.act});
        checkOutput("A_frame_done", {63'd0, a_done}, {63'd0, ea.done});
        if (qa.size() == 0) win_a = 1'b0;
      end
    end
  end

  // Monitor for the 4-lane DUT, same windowing as above.
  always @(negedge clk) begin
    if (!rst_b_n) begin
      win_b = 1'b0;
    end else begin
      if (!win_b && (b_act || b_done)) begin
        if (qb.size() != 0) win_b = 1'b1;
        else checkOutput("B_unexpected_activity", {62'd0, b_act, b_done}, 64'd0);
      end
      if (win_b) begin
        eb = qb.pop_front();
        checkOutput("B_data", {32'd0, b_data}, eb.data);
        checkOutput("B_ctrl", {60'd0, b_ctrl}, {56'd0, eb.ctrl});
        checkOutput("B_tx_active", {63'd0, b_act}, {63'd0, eb.act});
        checkOutput("B_frame_done", {63'd0, b_done}, {63'd0, eb.done});
        if (qb.size() == 0) win_b = 1'b0;
      end
    end
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    a_if.i_tdata = '0; a_if.i_tkeep = '0; a_if.i_tvalid = 1'b0; a_if.i_tlast = 1'b0; a_if.i_terr = 1'b0;
    b_if.i_tdata = '0; b_if.i_tkeep = '0; b_if.i_tvalid = 1'b0; b_if.i_tlast = 1'b0; b_if.i_terr = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("A_reset_data", a_data, IDLE8);
    checkOutput("A_reset_ctrl", {56'd0, a_ctrl}, 64'hFF);
    checkOutput("A_reset_flags", {61'd0, a_act, a_done, a_if.o_tready}, 64'd0);
    checkOutput("B_reset_data", {32'd0, b_data}, IDLE4);
    checkOutput("B_reset_ctrl", {60'd0, b_ctrl}, 64'hF);
    checkOutput("B_reset_flags", {61'd0, b_act, b_done, b_if.o_tready}, 64'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] 8-lane 64-byte frame");
    exp_pre(1'b0);
    exp_data(1'b0, 1, 64, 0, 8);
    push_exp(1'b0, 64'h07070707070707FD, 8'hFF, 1'b1, 1'b1);
    exp_idle(1'b0, 2);
    applyStimulus(1'b0, 64, 1, -1, 99, 1'b0);
    wait_drain(1'b0);

    $display("[TB] 8-lane 20-byte frame with padding");
    exp_pre(1'b0);
    exp_data(1'b0, 2, 20, 0, 3);
    for (int i = 0; i < 4; i++) push_exp(1'b0, 64'd0, 8'h00, 1'b1, 1'b0);
    push_exp(1'b0, 64'h070707FD00000000, 8'hF0, 1'b1, 1'b1);
    exp_idle(1'b0, 2);
    applyStimulus(1'b0, 20, 2, -1, 99, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("A_pad_tready", {63'd0, a_if.o_tready}, 64'd0);
      @(negedge clk);
    end
    wait_drain(1'b0);

    $display("[TB] 8-lane frame with error on beat 3");
    exp_pre(1'b0);
    exp_data(1'b0, 5, 64, 0, 3);
    push_exp(1'b0, 64'hFEFEFEFEFEFEFEFE, 8'hFF, 1'b1, 1'b0);
    exp_data(1'b0, 5, 64, 4, 8);
    push_exp(1'b0, 64'h07070707070707FD, 8'hFF, 1'b1, 1'b1);
    exp_idle(1'b0, 2);
    applyStimulus(1'b0, 64, 5, 3, 99, 1'b0);
    wait_drain(1'b0);

    $display("[TB] 4-lane 61-byte frame");
    exp_pre(1'b1);
    exp_data(1'b1, 3, 61, 0, 15);
    push_exp(1'b1, 64'h000000000707FD00 | beat_word(4, 3, 61, 15), 8'h0E, 1'b1, 1'b1);
    exp_idle(1'b1, 4);
    applyStimulus(1'b1, 61, 3, -1, 99, 1'b0);
    wait_drain(1'b1);

    $display("[TB] 4-lane back-to-back frames with 3-word gap");
    exp_pre(1'b1);
    exp_data(1'b1, 4, 61, 0, 15);
    push_exp(1'b1, 64'h000000000707FD00 | beat_word(4, 4, 61, 15), 8'h0E, 1'b1, 1'b1);
    exp_idle(1'b1, 3);
    exp_pre(1'b1);
    exp_data(1'b1, 9, 64, 0, 16);
    push_exp(1'b1, 64'h00000000070707FD, 8'h0F, 1'b1, 1'b1);
    exp_idle(1'b1, 4);
    applyStimulus(1'b1, 61, 4, -1, 99, 1'b1);
    applyStimulus(1'b1, 64, 9, -1, 99, 1'b0);
    wait_drain(1'b1);

    $display("[TB] 8-lane reset during DATA");
    exp_pre(1'b0);
    exp_data(1'b0, 7, 64, 0, 4);
    applyStimulus(1'b0, 64, 7, -1, 4, 1'b0);
    #1 rst_a_n = 1'b0;
    #1;
    checkOutput("A_midreset_data", a_data, IDLE8);
    checkOutput("A_midreset_ctrl", {56'd0, a_ctrl}, 64'hFF);
    checkOutput("A_midreset_flags", {61'd0, a_act, a_done, a_if.o_tready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (6) @(negedge clk);
    exp_pre(1'b0);
    exp_data(1'b0, 8, 64, 0, 8);
    push_exp(1'b0, 64'h07070707070707FD, 8'hFF, 1'b1, 1'b1);
    exp_idle(1'b0, 2);
    applyStimulus(1'b0, 64, 8, -1, 99, 1'b0);
    wait_drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
